// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file sizing and scoreboard state encoding
package regfile_pkg;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 2;

    // Saturation point of a per-register pending counter
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - pending-write counter for one architectural register
module sb_entry
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_wb_hit,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;

    // A writeback only retires a pending write if one exists; otherwise it is flagged
    assign w_dec       = i_wb_hit & (r_cnt != '0);
    assign o_underflow = i_wb_hit & (r_cnt == '0);

    // Counter: clear wins; simultaneous issue and retire cancel out
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !i_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - issue-side pending-write scoreboard with drain and flush
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wr_en,
    input  logic [SEL_W-1:0]    issue_wr_sel,
    input  logic                rd1_en,
    input  logic [SEL_W-1:0]    rd1_sel,
    input  logic                rd2_en,
    input  logic [SEL_W-1:0]    rd2_sel,
    input  logic                wb_valid,
    input  logic [SEL_W-1:0]    wb_sel,
    input  logic                drain_req,
    input  logic                flush,
    output logic                issue_ready,
    output logic                drained,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_underflow;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_wb_hit;
    logic [NUM_REGS-1:0] w_zero_next;
    logic                w_src1_ok;
    logic                w_src2_ok;
    logic                w_dst_ok;
    logic                w_accept;
    sb_state_t           r_state;
    sb_state_t           w_state_next;
    logic                r_drained;
    logic                r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            assign w_wb_hit[gi] = wb_valid & (wb_sel == SEL_W'(gi));
            assign w_inc[gi]    = w_accept & issue_wr_en & (issue_wr_sel == SEL_W'(gi));
            // Inc is never asserted while draining, so only the retire path can empty a counter
            assign w_zero_next[gi] = (w_cnt[gi] == '0) |
                                     ((w_cnt[gi] == CNT_W'(1)) & w_wb_hit[gi]);

            sb_entry u_entry (
                .clk         (clk),
                .rst         (rst),
                .i_inc       (w_inc[gi]),
                .i_wb_hit    (w_wb_hit[gi]),
                .i_clear     (flush),
                .o_cnt       (w_cnt[gi]),
                .o_busy      (w_busy[gi]),
                .o_underflow (w_underflow[gi])
            );
        end
    endgenerate

    // Hazard checks; sources consult only the old pending state, and the RF bypass
    // lets a read through when its last outstanding write lands this cycle
    always_comb begin
        w_src1_ok = !rd1_en | (w_cnt[rd1_sel] == '0) |
                    ((w_cnt[rd1_sel] == CNT_W'(1)) & w_wb_hit[rd1_sel]);
        w_src2_ok = !rd2_en | (w_cnt[rd2_sel] == '0) |
                    ((w_cnt[rd2_sel] == CNT_W'(1)) & w_wb_hit[rd2_sel]);
        w_dst_ok  = !issue_wr_en | (w_cnt[issue_wr_sel] != CNT_MAX) | w_wb_hit[issue_wr_sel];
    end

    assign issue_ready = (r_state == RUN) & !drain_req & !flush & w_src1_ok & w_src2_ok & w_dst_ok;
    assign w_accept    = issue_valid & issue_ready;

    // Drain sequencing: a flush empties everything, so it also completes a drain
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (drain_req) w_state_next = DRAIN;
            DRAIN:   if (flush || (&w_zero_next)) w_state_next = DONE;
            DONE:    w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // State register and the completion pulse that accompanies DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= RUN;
            r_drained <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_drained <= (w_state_next == DONE);
        end
    end

    // Sticky underflow flag; writebacks squashed by a flush do not count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (!flush && (|w_underflow)) begin
            r_err <= 1'b1;
        end
    end

    assign drained  = r_drained;
    assign busy_vec = w_busy;
    assign err      = r_err;

endmodule
